// File: rtl/bus_seq_pkg.sv
// ============================================================================
// Module : bus_seq_pkg
// Brief  : Shared state encoding, bus phase codes and CTRL bit map for the
//          6502 bus cycle sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_seq_pkg;

    typedef enum logic [2:0] {
        ST_LATCH = 3'd0,
        ST_ALO   = 3'd1,
        ST_AHI   = 3'd2,
        ST_CTRL  = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_ALO  = 3'd1;
    localparam logic [2:0] PH_AHI  = 3'd2;
    localparam logic [2:0] PH_CTRL = 3'd3;
    localparam logic [2:0] PH_DATA = 3'd4;

    localparam int CTRL_RW_BIT   = 0;
    localparam int CTRL_SYNC_BIT = 1;

    // Wait counter never narrower than 4 bits.
    function automatic int wait_cnt_width(input int max_wait);
        return ($clog2(max_wait + 1) < 4) ? 4 : $clog2(max_wait + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_wait_timer.sv
// ============================================================================
// Module : bus_wait_timer
// Brief  : Saturating wait-cycle counter with clear/enable and a done flag
//          raised once the count reaches MAX_WAIT.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_wait_timer
    import bus_seq_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CW       = wait_cnt_width(MAX_WAIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam logic [CW-1:0] C_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/bus_cycle_sequencer.sv
// ============================================================================
// Module : bus_cycle_sequencer
// Brief  : Frames one 6502 bus cycle onto an 8-bit multiplexed bus plus
//          bidirectional data pins, pacing the core with a step pulse.
//          Optional macro BUS_WAIT_EN enables ext_wait stretching/timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_cycle_sequencer
    import bus_seq_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] core_addr,
    input  logic        core_rw,
    input  logic        core_sync,
    input  logic [7:0]  core_wdata,
    output logic        core_step,
    output logic [7:0]  core_rdata,
    input  logic [7:0]  ext_data_in,
    output logic [7:0]  ext_data_out,
    output logic [7:0]  ext_data_oe,
    input  logic        ext_wait,
    output logic [7:0]  bus_out,
    output logic [2:0]  bus_phase,
    output logic        timeout
);

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_addr;
    logic        r_rw;
    logic        r_sync;
    logic [7:0]  r_wdata;

    logic        w_load;
    logic [15:0] w_addr;
    logic        w_rw;
    logic        w_sync;
    logic [7:0]  w_wdata;
    logic        w_data_done;

    logic [7:0]  w_bus;
    logic [2:0]  w_ph;
    logic [7:0]  w_oe;
    logic [7:0]  w_dout;
    logic        w_step;

    logic [7:0]  r_bus;
    logic [2:0]  r_ph;
    logic [7:0]  r_oe;
    logic [7:0]  r_dout;
    logic        r_step;
    logic [7:0]  r_rdata;

    // Outputs for the coming state are built from the values the shadow
    // registers will hold, so ALO already shows the freshly captured address.
    assign w_load  = (r_state == ST_LATCH) && ena;
    assign w_addr  = w_load ? core_addr  : r_addr;
    assign w_rw    = w_load ? core_rw    : r_rw;
    assign w_sync  = w_load ? core_sync  : r_sync;
    assign w_wdata = w_load ? core_wdata : r_wdata;

`ifdef BUS_WAIT_EN
    logic w_tmr_done;
    logic r_timeout;

    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state == ST_CTRL),
        .i_en   ((r_state == ST_DATA) && ext_wait),
        .o_done (w_tmr_done)
    );

    assign w_data_done = !ext_wait || w_tmr_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == ST_DATA) && ext_wait && w_tmr_done;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused;

    assign w_unused    = ext_wait | (MAX_WAIT < 0);
    assign w_data_done = 1'b1;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LATCH: w_next = ena ? ST_ALO : ST_LATCH;
            ST_ALO:   w_next = ST_AHI;
            ST_AHI:   w_next = ST_CTRL;
            ST_CTRL:  w_next = ST_DATA;
            ST_DATA:  w_next = w_data_done ? ST_DONE : ST_DATA;
            ST_DONE:  w_next = ST_LATCH;
            default:  w_next = ST_LATCH;
        endcase
    end

    always_comb begin
        w_bus  = 8'h00;
        w_ph   = PH_IDLE;
        w_oe   = 8'h00;
        w_dout = 8'h00;
        w_step = 1'b0;
        case (w_next)
            ST_ALO: begin
                w_bus = w_addr[7:0];
                w_ph  = PH_ALO;
            end
            ST_AHI: begin
                w_bus = w_addr[15:8];
                w_ph  = PH_AHI;
            end
            ST_CTRL: begin
                w_bus[CTRL_RW_BIT]   = w_rw;
                w_bus[CTRL_SYNC_BIT] = w_sync;
                w_ph                 = PH_CTRL;
                if (!w_rw) begin
                    w_oe   = 8'hFF;
                    w_dout = w_wdata;
                end
            end
            ST_DATA: begin
                w_ph = PH_DATA;
                if (!w_rw) begin
                    w_oe   = 8'hFF;
                    w_dout = w_wdata;
                end
            end
            ST_DONE: w_step = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LATCH;
            r_addr  <= 16'h0000;
            r_rw    <= 1'b0;
            r_sync  <= 1'b0;
            r_wdata <= 8'h00;
            r_bus   <= 8'h00;
            r_ph    <= PH_IDLE;
            r_oe    <= 8'h00;
            r_dout  <= 8'h00;
            r_step  <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_next;
            r_addr  <= w_addr;
            r_rw    <= w_rw;
            r_sync  <= w_sync;
            r_wdata <= w_wdata;
            r_bus   <= w_bus;
            r_ph    <= w_ph;
            r_oe    <= w_oe;
            r_dout  <= w_dout;
            r_step  <= w_step;
            if ((r_state == ST_DATA) && w_data_done && r_rw) begin
                r_rdata <= ext_data_in;
            end
        end
    end

    assign core_step    = r_step;
    assign core_rdata   = r_rdata;
    assign ext_data_out = r_dout;
    assign ext_data_oe  = r_oe;
    assign bus_out      = r_bus;
    assign bus_phase    = r_ph;

endmodule

`default_nettype wire
